// File: rtl/vm_pkg.sv
// vm_pkg: shared constants for the vending-machine payment stage.
package vm_pkg;
    localparam int MONEY_W_D = 10;
    localparam logic [1:0] PAY_IDLE      = 2'd0;
    localparam logic [1:0] PAY_COLLECT   = 2'd1;
    localparam logic [1:0] PAY_OK_HOLD   = 2'd2;
    localparam logic [1:0] PAY_FAIL_HOLD = 2'd3;
    localparam int COIN1_V  = 1;
    localparam int COIN5_V  = 5;
    localparam int COIN10_V = 10;
endpackage

// File: rtl/pay_ctrl_tick_gen.sv
// tick_gen: TICK_DIV prescaler with synchronous restart and one-cycle tick.
// The cycle in which restart is asserted counts as the first prescaler cycle.
module tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_tick
);
    localparam int W = $clog2(TICK_DIV + 1);
    logic [W-1:0] r_cnt;
    assign o_tick = (r_cnt == W'(TICK_DIV - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else r_cnt <= i_restart ? W'(TICK_DIV > 1 ? 1 : 0) : o_tick ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/pay_ctrl.sv
// pay_ctrl: coin accumulation, timeout, result pulses and change/refund for the payment stage.
module pay_ctrl
    import vm_pkg::*;
#(
    parameter int TICK_DIV    = 100_000_000,
    parameter int PAY_TIMEOUT = 30,
    parameter int MSG_HOLD    = 3,
    parameter int MONEY_W     = MONEY_W_D
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pay_start,
    input  logic               pay_abort,
    input  logic [7:0]         price,
    input  logic [2:0]         amount,
    input  logic               coin_1,
    input  logic               coin_5,
    input  logic               coin_10,
    input  logic               cancel,
    output logic [MONEY_W-1:0] paid,
    output logic [MONEY_W-1:0] due,
    output logic [MONEY_W-1:0] change,
    output logic               pay_ok,
    output logic               pay_fail,
    output logic               finish,
    output logic               busy
);
    localparam logic [MONEY_W-1:0] MAXV = '1;
    logic [1:0]         r_state, w_next;
    logic [MONEY_W-1:0] r_paid, r_due, r_change, w_due, w_new;
    logic [MONEY_W:0]   w_sum;
    logic [10:0]        w_prod;
    logic [7:0]         r_ticks;
    logic               r_entry, r_ok, r_fail, r_finish;
    logic               w_coin, w_tick, w_tick_v, w_restart, w_ok, w_timeout, w_hold_done;

    assign w_prod = 11'(price) * 11'(amount);
    assign w_due  = (w_prod > 11'(MAXV)) ? MAXV : MONEY_W'(w_prod);
    assign w_sum  = (MONEY_W+1)'(r_paid) + (MONEY_W+1)'(coin_1 ? COIN1_V : 0)
                  + (MONEY_W+1)'(coin_5 ? COIN5_V : 0) + (MONEY_W+1)'(coin_10 ? COIN10_V : 0);
    assign w_new  = (w_sum > (MONEY_W+1)'(MAXV)) ? MAXV : w_sum[MONEY_W-1:0];
    assign w_coin = coin_1 | coin_5 | coin_10;
    assign w_ok   = (w_new >= r_due);
    // Restart counts from the first cycle of a new state, or from the coin cycle itself.
    assign w_restart   = r_entry | ((r_state == PAY_COLLECT) & w_coin);
    assign w_tick_v    = w_tick & ~w_restart;
    assign w_timeout   = w_tick_v & (r_ticks == 8'(PAY_TIMEOUT - 1));
    assign w_hold_done = w_tick_v & (r_ticks == 8'(MSG_HOLD - 1));

    always_comb begin
        w_next = r_state;
        if (r_state == PAY_IDLE)
            w_next = pay_start ? ((w_due == '0) ? PAY_FAIL_HOLD : PAY_COLLECT) : PAY_IDLE;
        else if (pay_abort)
            w_next = PAY_IDLE;
        else if (r_state == PAY_COLLECT)
            w_next = w_ok ? PAY_OK_HOLD : (cancel | w_timeout) ? PAY_FAIL_HOLD : PAY_COLLECT;
        else if (w_hold_done)
            w_next = PAY_IDLE;
    end

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .i_restart(w_restart),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= PAY_IDLE;
            r_paid   <= '0;
            r_due    <= '0;
            r_change <= '0;
            r_ticks  <= '0;
            r_entry  <= 1'b0;
            r_ok     <= 1'b0;
            r_fail   <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_entry  <= (w_next != r_state);
            r_ok     <= 1'b0;
            r_fail   <= 1'b0;
            r_finish <= 1'b0;
            r_ticks  <= w_restart ? '0 : w_tick ? r_ticks + 1'b1 : r_ticks;
            case (r_state)
                PAY_IDLE: if (pay_start) begin
                    r_due    <= w_due;
                    r_paid   <= '0;
                    r_change <= '0;
                    r_fail   <= (w_due == '0);
                end
                PAY_COLLECT: if (pay_abort) begin
                    r_paid <= '0;
                    r_due  <= '0;
                end else begin
                    r_paid <= w_new;
                    if (w_ok) begin
                        r_ok     <= 1'b1;
                        r_change <= w_new - r_due;
                    end else if (w_next == PAY_FAIL_HOLD) begin
                        r_fail   <= 1'b1;
                        r_change <= w_new;
                    end
                end
                default: r_finish <= w_hold_done & ~pay_abort;
            endcase
        end
    end

    assign paid     = r_paid;
    assign due      = r_due;
    assign change   = r_change;
    assign pay_ok   = r_ok;
    assign pay_fail = r_fail;
    assign finish   = r_finish;
    assign busy     = (r_state != PAY_IDLE);
endmodule

// File: doc/pay_ctrl.md
Name: pay_ctrl

Overview:
- Payment stage directly downstream of the mode FSM. It runs while the FSM is in its payment state.
- Accumulates debounced coin pulses against the order total (price × amount) and enforces a payment timeout.
- Issues pay_ok / pay_fail, computes change or refund, and raises the `finish` pulse that releases the FSM from its success/failure display states.

Parameters:
- TICK_DIV, 100_000_000, clk cycles per 1 s tick (benches use 4)
- PAY_TIMEOUT, 30, ticks without an accepted coin before auto-fail
- MSG_HOLD, 3, ticks the success/failure result is held before `finish`
- MONEY_W, 10, width of the paid/due/change registers

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- pay_start  in  1  one-cycle pulse: mode FSM entered payment
- pay_abort  in  1  level: main switch off or admin mode entered
- price  in  8  unit price of the selected item
- amount  in  3  quantity selected (0..7)
- coin_1  in  1  one-cycle pulse, value 1
- coin_5  in  1  one-cycle pulse, value 5
- coin_10  in  1  one-cycle pulse, value 10
- cancel  in  1  one-cycle pulse (return key)
- paid  out  MONEY_W  money inserted so far
- due  out  MONEY_W  order total
- change  out  MONEY_W  change on success, or refund on failure
- pay_ok  out  1  one-cycle pulse
- pay_fail  out  1  one-cycle pulse
- finish  out  1  one-cycle pulse at end of result hold
- busy  out  1  high in any state except IDLE

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset: all outputs are 0 and the FSM is in IDLE. Reset mid-operation discards the transaction and generates no pulse.
- FSM states: IDLE, COLLECT, OK_HOLD, FAIL_HOLD.
- IDLE:
  - On pay_start, latch due = price*amount (11-bit product, saturated to 2^MONEY_W-1) and clear paid.
  - If the product is 0, go to FAIL_HOLD, pulse pay_fail and set change = 0.
  - Otherwise go to COLLECT.
  - change keeps its last value until the next pay_start.
- COLLECT:
  - Each cycle, new = paid + (1 if coin_1) + (5 if coin_5) + (10 if coin_10). Simultaneous coins all count.
  - The sum saturates at 2^MONEY_W-1.
  - Any accepted coin restarts the timeout count and the tick prescaler.
- COLLECT priority, highest first:
  1. pay_abort: go to IDLE, clear paid and due, no pulses.
  2. new >= due: go to OK_HOLD, change = new - due, pay_ok pulses the next cycle. Success wins over a same-cycle cancel.
  3. cancel: go to FAIL_HOLD, change = new (full refund, including any same-cycle coin), pay_fail pulses.
  4. Timeout (PAY_TIMEOUT ticks elapsed): same as cancel.
- Latency: paid updates one cycle after a coin pulse. pay_ok / pay_fail are registered and assert in the first cycle in OK_HOLD / FAIL_HOLD.
- OK_HOLD / FAIL_HOLD:
  - Coins and cancel are ignored (no accumulation).
  - The prescaler restarts on state entry.
  - After MSG_HOLD ticks, pulse finish for 1 cycle and go to IDLE.
  - pay_abort: go to IDLE immediately with no finish pulse.
- pay_start outside IDLE is ignored.
- busy = (state != IDLE).

Decomposition:
- Shared package vm_pkg holds:
  - pay state encoding (2-bit localparams)
  - coin value constants COIN1_V, COIN5_V, COIN10_V
  - MONEY_W default
- Natural sub-module: tick_gen. It is a TICK_DIV prescaler with a synchronous restart input and a one-cycle tick output, reused for the timeout and the hold counters.

Test Plan (TICK_DIV=4, PAY_TIMEOUT=5, MSG_HOLD=2):
- Exact payment: price=12, amount=2 (due=24); coins 10, 10, 1, 1, 1, 1 → paid=24, pay_ok one cycle after the last coin, change=0; finish 8 cycles after pay_ok.
- Overpay with simultaneous coins: due=7; coin_5 and coin_10 in the same cycle → paid=15, change=8, pay_ok.
- Cancel refund: due=30; coins 10, 5, then cancel → pay_fail, change=15, finish after the hold; paid is not updated by coins pulsed during FAIL_HOLD.
- Timeout: due=20; one coin_5, then idle 20 cycles → pay_fail exactly 20 cycles after the coin, change=5. Check the restart: a coin inserted at cycle 15 delays pay_fail by another 20 cycles.
- Edge cases:
  - amount=0 → immediate pay_fail, change=0.
  - coin_10 together with cancel when paid=15, due=20 → pay_ok, change=5 (success wins).
- Abort and reset: pay_abort during COLLECT with paid=9 → IDLE, no pay_fail, no finish. Assert rst mid-OK_HOLD → all outputs 0 immediately, no finish.
